pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_if.sv | 29 ++
 rtl/pipe_stage_reg.sv | 104 ++++++++++
 tb/tb_pipe_stage_reg.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage register: upstream entry in, head entry out.
// The stage itself takes the slave side; whoever feeds and drains it takes the master side.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [31:0]       in_pc;
  logic              in_bd;
  logic [4:0]        in_exc;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       out_pc;
  logic              out_bd;
  logic [4:0]        out_exc;

  modport master (
    output in_valid, in_data, in_pc, in_bd, in_exc, out_ready,
    input  in_ready, out_valid, out_data, out_pc, out_bd, out_exc
  );

  modport slave (
    input  in_valid, in_data, in_pc, in_bd, in_exc, out_ready,
    output in_ready, out_valid, out_data, out_pc, out_bd, out_exc
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with flush and a saturating bubble counter.
// Handshake outputs decode only from the state register, so no ready/valid combinational path.
module pipe_stage_reg #(
  parameter int unsigned DATA_W   = 128,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter bit          KEEP_PC  = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
    logic              bd;
    logic [4:0]        exc;
  } entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q;
  entry_t           main_q;
  entry_t           skid_q;
  entry_t           in_ent;
  entry_t           flush_ent;
  logic             accept;
  logic             drain;
  logic [CNT_W-1:0] cnt_q;

  assign in_ent = '{data: bus.in_data, pc: bus.in_pc, bd: bus.in_bd, exc: bus.in_exc};

  // Bubble left behind by a flush: nop payload, no exception, PC per KEEP_PC.
  assign flush_ent = '{data: '0, pc: (KEEP_PC ? bus.in_pc : RESET_PC), bd: bus.in_bd, exc: '0};

  assign bus.in_ready  = (state_q != StTwo);
  assign bus.out_valid = (state_q != StEmpty);
  assign accept        = bus.in_valid & bus.in_ready;
  assign drain         = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= '{data: '0, pc: RESET_PC, bd: 1'b0, exc: '0};
      skid_q  <= '{data: '0, pc: RESET_PC, bd: 1'b0, exc: '0};
    end else if (flush) begin
      state_q <= StEmpty;
      main_q  <= flush_ent;
      skid_q  <= flush_ent;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q  <= in_ent;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (accept && drain) begin
            main_q <= in_ent;
          end else if (accept) begin
            skid_q  <= in_ent;
            state_q <= StTwo;
          end else if (drain) begin
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          // in_ready is low here, so a drain never coincides with an accept.
          if (drain) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt_q <= '0;
    end else if ((state_q == StEmpty) && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bubble_cnt   = cnt_q;
  assign bus.out_data = (state_q == StEmpty) ? '0 : main_q.data;
  assign bus.out_pc   = main_q.pc;
  assign bus.out_bd   = main_q.bd;
  assign bus.out_exc  = main_q.exc;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios followed by random traffic, all checked
// against a queue-based model of the stage's FIFO/flush/bubble-count behaviour.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam bit          KEEP_PC  = 1'b1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
    logic              bd;
    logic [4:0]        exc;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             cnt_clr;
  logic [CNT_W-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: queued entries in order, plus whatever the head registers last showed.
  ent_t        q[$];
  ent_t        disp;
  int unsigned mcnt;

  pipe_stage_reg_if #(.DATA_W(DATA_W)) bus ();

  pipe_stage_reg #(
    .DATA_W  (DATA_W),
    .RESET_PC(RESET_PC),
    .KEEP_PC (KEEP_PC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the edge, while inputs still hold their pre-edge values.
  task automatic model_step();
    bit   was_empty;
    bit   acc;
    bit   drn;
    ent_t in_e;
    was_empty = (q.size() == 0);
    acc       = bus.in_valid && (q.size() < 2);
    drn       = (q.size() > 0) && bus.out_ready;
    in_e      = '{data: bus.in_data, pc: bus.in_pc, bd: bus.in_bd, exc: bus.in_exc};
    if (reset) begin
      q.delete();
      disp = '{data: '0, pc: RESET_PC, bd: 1'b0, exc: '0};
      mcnt = 0;
    end else begin
      if (flush) begin
        q.delete();
        disp = '{data: '0, pc: (KEEP_PC ? bus.in_pc : RESET_PC), bd: bus.in_bd, exc: '0};
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(in_e);
        if (q.size() > 0) disp = q[0];
      end
      if (cnt_clr) mcnt = 0;
      else if (was_empty && mcnt < CNT_MAX) mcnt++;
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
    chk("out_data", 64'(bus.out_data), (q.size() > 0) ? 64'(disp.data) : 64'd0);
    chk("out_pc", 64'(bus.out_pc), 64'(disp.pc));
    chk("out_bd", 64'(bus.out_bd), 64'(disp.bd));
    chk("out_exc", 64'(bus.out_exc), 64'(disp.exc));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(mcnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send(input logic v, input logic [31:0] pc, input logic bd, input logic [4:0] exc);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_bd    = bd;
    bus.in_exc   = exc;
    bus.in_data  = $urandom();
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    cnt_clr       = 1'b0;
    bus.out_ready = 1'b0;
    send(1'b0, 32'h0, 1'b0, 5'd0);
    tick();
    reset = 1'b0;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_pc", 64'(bus.out_pc), 64'h3000);
    chk("rst_cnt", 64'(bubble_cnt), 64'd0);

    // Streaming at full throughput.
    bus.out_ready = 1'b1;
    send(1'b1, 32'h3000, 1'b0, 5'd0); tick();
    chk("stream_pc0", 64'(bus.out_pc), 64'h3000);
    send(1'b1, 32'h3004, 1'b1, 5'd3); tick();
    chk("stream_pc1", 64'(bus.out_pc), 64'h3004);
    send(1'b1, 32'h3008, 1'b0, 5'd0); tick();
    chk("stream_pc2", 64'(bus.out_pc), 64'h3008);
    chk("stream_ready", 64'(bus.in_ready), 64'd1);
    send(1'b0, 32'h0, 1'b0, 5'd0); tick();
    chk("drain_empty_data", 64'(bus.out_data), 64'd0);
    chk("drain_keep_pc", 64'(bus.out_pc), 64'h3008);

    // Backpressure into the skid entry.
    bus.out_ready = 1'b0;
    send(1'b1, 32'h3000, 1'b0, 5'd0); tick();
    send(1'b1, 32'h3004, 1'b0, 5'd0); tick();
    chk("bp_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_pc", 64'(bus.out_pc), 64'h3000);
    send(1'b0, 32'h0, 1'b0, 5'd0); tick();
    chk("bp_stable", 64'(bus.out_pc), 64'h3000);
    bus.out_ready = 1'b1; tick();
    chk("bp_second", 64'(bus.out_pc), 64'h3004);
    tick();
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // Flush while holding two entries.
    bus.out_ready = 1'b0;
    send(1'b1, 32'h3000, 1'b0, 5'd1); tick();
    send(1'b1, 32'h3004, 1'b0, 5'd2); tick();
    flush = 1'b1;
    send(1'b1, 32'h3010, 1'b1, 5'd7); tick();
    flush = 1'b0;
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_data", 64'(bus.out_data), 64'd0);
    chk("fl_pc", 64'(bus.out_pc), 64'h3010);
    chk("fl_bd", 64'(bus.out_bd), 64'd1);
    chk("fl_ready", 64'(bus.in_ready), 64'd1);
    send(1'b0, 32'h0, 1'b0, 5'd0);
    bus.out_ready = 1'b1;
    tick(); tick();
    chk("fl_no_skid", 64'(bus.out_valid), 64'd0);

    // Bubble counter saturation and clear.
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 64'(bubble_cnt), 64'(CNT_MAX));
    cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0;
    chk("clr_cnt", 64'(bubble_cnt), 64'd0);
    tick();
    chk("cnt_one", 64'(bubble_cnt), 64'd1);
    tick();
    chk("cnt_two", 64'(bubble_cnt), 64'd2);

    // Reset in TWO with flush and accept pending.
    bus.out_ready = 1'b0;
    send(1'b1, 32'h3040, 1'b1, 5'd4); tick();
    send(1'b1, 32'h3044, 1'b0, 5'd5); tick();
    reset   = 1'b1;
    flush   = 1'b1;
    cnt_clr = 1'b1;
    send(1'b1, 32'h3050, 1'b1, 5'd6);
    bus.out_ready = 1'b1;
    tick();
    reset   = 1'b0;
    flush   = 1'b0;
    cnt_clr = 1'b0;
    chk("rst2_valid", 64'(bus.out_valid), 64'd0);
    chk("rst2_pc", 64'(bus.out_pc), 64'h3000);
    chk("rst2_cnt", 64'(bubble_cnt), 64'd0);
    send(1'b1, 32'h3020, 1'b0, 5'd0); tick();
    chk("rst2_first", 64'(bus.out_pc), 64'h3020);
    chk("rst2_first_v", 64'(bus.out_valid), 64'd1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      send(($urandom_range(0, 9) < 7), $urandom(), 1'($urandom()), 5'($urandom()));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 15) == 0);
      cnt_clr       = ($urandom_range(0, 31) == 0);
      reset         = ($urandom_range(0, 127) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
